// File: rtl/clock_cfg_sequencer_if.sv
// ---------------------------------------------------------------------------
// clock_cfg_sequencer_if
//
// Bundles the request side (from the housekeeping SPI registers), the PLL
// status input, and the applied configuration and status outputs of the
// clock configuration sequencer.
//
//   req_ext_clk_sel  requested source (1 = external pad clock, 0 = PLL)
//   req_sel          requested core clock divider select
//   req_sel2         requested user (90-degree) clock divider select
//   pll_stable       PLL running and trimmed
//   ext_clk_sel      applied source select
//   sel, sel2        applied divider selects
//   busy             sequence in progress
//   done             one-cycle completion pulse
//   err              sticky PLL-switch-refused flag
//
// master: the requester / observer side.  slave: the sequencer.
// ---------------------------------------------------------------------------
interface clock_cfg_sequencer_if;
  logic       req_ext_clk_sel;
  logic [2:0] req_sel;
  logic [2:0] req_sel2;
  logic       pll_stable;
  logic       ext_clk_sel;
  logic [2:0] sel;
  logic [2:0] sel2;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output req_ext_clk_sel, req_sel, req_sel2, pll_stable,
    input  ext_clk_sel, sel, sel2, busy, done, err
  );

  modport slave (
    input  req_ext_clk_sel, req_sel, req_sel2, pll_stable,
    output ext_clk_sel, sel, sel2, busy, done, err
  );
endinterface

// File: rtl/clock_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// clock_cfg_sequencer
//
// Applies a requested clock configuration (source select + two divider
// selects) to the clocking block in a safe order.  A changed request must be
// stable for SETTLE_CYCLES cycles before it is accepted; each output step is
// followed by a WAIT_CYCLES hold.  Switching to the PLL is refused while
// pll_stable is low.
//
// Ports:
//   wb_clk_i  system clock, rising edge
//   wb_rst_i  synchronous active-high reset
//   cfg       request / applied-configuration / status bundle (slave side)
//
// Output step timing: the applied registers are loaded on the clock edge
// that enters STEP1 / STEP2, so the new values are visible during the STEP
// cycle itself.  The PLL-stable check is made on that same edge.
// ---------------------------------------------------------------------------
module clock_cfg_sequencer #(
  parameter int SETTLE_CYCLES = 4,
  parameter int WAIT_CYCLES   = 16,
  parameter int CNT_W         = 5
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  clock_cfg_sequencer_if.slave  cfg
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_STEP1, S_WAIT1, S_STEP2, S_WAIT2, S_DONE
  } state_t;

  // Kind of sequence being run, decided when the snapshot is taken.
  typedef enum logic [1:0] {
    M_SAME, M_TO_PLL, M_TO_EXT
  } mode_t;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(WAIT_CYCLES - 1);

  state_t           state_q, state_d;
  mode_t            mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       cmp_q, cmp_d;
  logic [5:0]       snap_q, snap_d;     // snapshot dividers {sel, sel2}
  logic             refused_q, refused_d;
  logic             ext_q, ext_d;
  logic [2:0]       sel_q, sel_d;
  logic [2:0]       sel2_q, sel2_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [6:0] req_vec;
  logic [6:0] app_vec;

  assign req_vec = {cfg.req_ext_clk_sel, cfg.req_sel, cfg.req_sel2};
  assign app_vec = {ext_q, sel_q, sel2_q};

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    cmp_d     = cmp_q;
    snap_d    = snap_q;
    refused_d = refused_q;
    ext_d     = ext_q;
    sel_d     = sel_q;
    sel2_d    = sel2_q;
    err_d     = err_q;

    case (state_q)
      S_IDLE: begin
        if (req_vec != app_vec) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
          cmp_d   = req_vec;
        end
      end

      S_SETTLE: begin
        if (req_vec == app_vec) begin
          state_d = S_IDLE;
        end else if (req_vec != cmp_q) begin
          // Request moved: restart the stability window on the new value.
          cmp_d = req_vec;
          cnt_d = '0;
        end else if (cnt_q >= SETTLE_LAST) begin
          state_d   = S_STEP1;
          snap_d    = req_vec[5:0];
          refused_d = 1'b0;
          if (!req_vec[6] && ext_q) begin
            // Dividers first while still on the external clock.
            mode_d = M_TO_PLL;
            if (!cfg.pll_stable) begin
              err_d     = 1'b1;
              refused_d = 1'b1;
            end else begin
              sel_d  = req_vec[5:3];
              sel2_d = req_vec[2:0];
            end
          end else if (req_vec[6] && !ext_q) begin
            // Leave the PLL first, dividers change once on the pad clock.
            mode_d = M_TO_EXT;
            ext_d  = 1'b1;
          end else begin
            mode_d = M_SAME;
            sel_d  = req_vec[5:3];
            sel2_d = req_vec[2:0];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_STEP1: begin
        cnt_d   = '0;
        state_d = refused_q ? S_DONE : S_WAIT1;
      end

      S_WAIT1: begin
        if (cnt_q >= WAIT_LAST) begin
          state_d = S_STEP2;
          cnt_d   = '0;
          case (mode_q)
            M_TO_PLL: begin
              if (cfg.pll_stable) begin
                ext_d = 1'b0;
              end else begin
                // PLL lost during the hold: stay external, keep new dividers.
                err_d     = 1'b1;
                refused_d = 1'b1;
              end
            end
            M_TO_EXT: begin
              sel_d  = snap_q[5:3];
              sel2_d = snap_q[2:0];
            end
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_STEP2: begin
        cnt_d   = '0;
        state_d = refused_q ? S_DONE : S_WAIT2;
      end

      S_WAIT2: begin
        if (cnt_q >= WAIT_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
          // Only a completed PLL switch clears the sticky error.
          if (mode_q == M_TO_PLL) begin
            err_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status flags are registered alongside the state they describe.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= S_IDLE;
      mode_q    <= M_SAME;
      cnt_q     <= '0;
      cmp_q     <= '0;
      snap_q    <= '0;
      refused_q <= 1'b0;
      ext_q     <= 1'b1;
      sel_q     <= 3'd0;
      sel2_q    <= 3'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      cmp_q     <= cmp_d;
      snap_q    <= snap_d;
      refused_q <= refused_d;
      ext_q     <= ext_d;
      sel_q     <= sel_d;
      sel2_q    <= sel2_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign cfg.ext_clk_sel = ext_q;
  assign cfg.sel         = sel_q;
  assign cfg.sel2        = sel2_q;
  assign cfg.busy        = busy_q;
  assign cfg.done        = done_q;
  assign cfg.err         = err_q;

endmodule

// File: tb/tb_clock_cfg_sequencer.sv
module tb_clock_cfg_sequencer;
  localparam int SETTLE   = 4;
  localparam int WAITC    = 16;
  localparam int LAT_FULL = SETTLE + 1 + WAITC + 1 + WAITC + 1;   // 39

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  clock_cfg_sequencer_if cfg();

  clock_cfg_sequencer #(
    .SETTLE_CYCLES(SETTLE),
    .WAIT_CYCLES  (WAITC),
    .CNT_W        (5)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .cfg     (cfg)
  );

  int checks = 0;
  int errors = 0;

  // Bench-side view of what the applied configuration and err should be.
  logic [6:0] a_m;
  logic       err_m;
  logic [6:0] hist_a [0:127];

  typedef struct {
    logic [6:0] r;
    logic       pll;
    int         drop_at;
    logic [6:0] exp_mid;
    logic [6:0] exp_a;
    logic       exp_err;
    int         exp_lat;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] cur_a();
    return {cfg.ext_clk_sel, cfg.sel, cfg.sel2};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [6:0] r);
    cfg.req_ext_clk_sel = r[6];
    cfg.req_sel         = r[5:3];
    cfg.req_sel2        = r[2:0];
  endtask

  // Apply a request, wait for done, compare timing and results, then park
  // the request on the expected applied value so no retry follows.
  task automatic do_txn(input logic [6:0] r, input logic pll, input int drop_at,
                        input logic [6:0] em, input logic [6:0] ea,
                        input logic ee, input int el, input string name);
    int lat;
    logic [6:0] a0;
    a0 = a_m;
    drive_req(r);
    cfg.pll_stable = pll;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      tick();
      if (n == drop_at) cfg.pll_stable = 1'b0;
      hist_a[n] = cur_a();
      if (n == 1) check({name, ".busy_start"}, cfg.busy, 1);
      if (cfg.done) begin
        lat = n;
        break;
      end
    end
    drive_req(ea);
    check({name, ".latency"}, lat, el);
    if (lat >= SETTLE + 1) begin
      check({name, ".before_step1"}, hist_a[SETTLE], a0);
      check({name, ".at_step1"}, hist_a[SETTLE + 1], em);
    end
    if (lat >= SETTLE + WAITC + 2) begin
      check({name, ".end_wait1"}, hist_a[SETTLE + WAITC + 1], em);
      check({name, ".at_step2"}, hist_a[SETTLE + WAITC + 2], ea);
    end
    check({name, ".applied"}, cur_a(), ea);
    check({name, ".err"}, cfg.err, ee);
    tick();
    check({name, ".idle_after"}, {cfg.done, cfg.busy}, 2'b00);
    $display("txn %s: req=%0h pll=%0d drop=%0d lat=%0d applied=%0h err=%0d",
             name, r, pll, drop_at, lat, cur_a(), cfg.err);
    a_m   = ea;
    err_m = ee;
  endtask

  // Reference model: outcome of one stable request from the sequencing rules.
  task automatic model_txn(input logic [6:0] r, input logic pll, input int drop_at,
                           input string name);
    logic to_pll;
    logic [6:0] ea, em;
    logic ee;
    int el;
    to_pll = !r[6] && a_m[6];
    if (to_pll && !pll) begin
      em = a_m; ea = a_m; ee = 1'b1; el = SETTLE + 2;
    end else if (to_pll && drop_at != 0) begin
      em = {1'b1, r[5:0]}; ea = em; ee = 1'b1; el = SETTLE + 1 + WAITC + 2;
    end else begin
      ea = r;
      el = LAT_FULL;
      ee = to_pll ? 1'b0 : err_m;
      if (to_pll)                 em = {1'b1, r[5:0]};
      else if (r[6] && !a_m[6])   em = {1'b1, a_m[5:0]};
      else                        em = r;
    end
    do_txn(r, pll, drop_at, em, ea, ee, el, name);
  endtask

  initial begin
    int done_cycles [$];
    logic bad;
    logic [6:0] r, v1, v2;
    logic pll;
    int drop;

    //                 r            pll drop  mid          final        err lat
    vecs[0] = '{7'b1_010_001, 1'b0, 0,  7'b1_010_001, 7'b1_010_001, 1'b0, 39};
    vecs[1] = '{7'b0_001_001, 1'b1, 0,  7'b1_001_001, 7'b0_001_001, 1'b0, 39};
    vecs[2] = '{7'b1_100_000, 1'b0, 0,  7'b1_001_001, 7'b1_100_000, 1'b0, 39};
    vecs[3] = '{7'b0_011_101, 1'b0, 0,  7'b1_100_000, 7'b1_100_000, 1'b1, 6};
    vecs[4] = '{7'b1_111_111, 1'b0, 0,  7'b1_111_111, 7'b1_111_111, 1'b1, 39};
    vecs[5] = '{7'b0_111_111, 1'b1, 0,  7'b1_111_111, 7'b0_111_111, 1'b0, 39};
    vecs[6] = '{7'b0_010_011, 1'b0, 0,  7'b0_010_011, 7'b0_010_011, 1'b0, 39};
    vecs[7] = '{7'b1_101_010, 1'b1, 0,  7'b1_010_011, 7'b1_101_010, 1'b0, 39};
    vecs[8] = '{7'b0_101_101, 1'b1, 10, 7'b1_101_101, 7'b1_101_101, 1'b1, 23};
    vecs[9] = '{7'b1_000_000, 1'b1, 0,  7'b1_000_000, 7'b1_000_000, 1'b1, 39};

    // Reset state, then idle with a matching request.
    drive_req(7'b1_000_000);
    cfg.pll_stable = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset.applied", cur_a(), 7'b1_000_000);
    check("reset.status", {cfg.busy, cfg.done, cfg.err}, 3'b000);
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (cfg.busy || cfg.done || cur_a() != 7'b1_000_000) bad = 1'b1;
    end
    check("idle_hold.no_activity", bad, 0);
    a_m = 7'b1_000_000;
    err_m = 1'b0;

    // Table-driven vectors.
    foreach (vecs[i]) begin
      do_txn(vecs[i].r, vecs[i].pll, vecs[i].drop_at, vecs[i].exp_mid,
             vecs[i].exp_a, vecs[i].exp_err, vecs[i].exp_lat, $sformatf("vec%0d", i));
    end

    // Refused PLL request retries until the PLL comes up.
    drive_req(7'b0_001_001);
    cfg.pll_stable = 1'b0;
    for (int n = 1; n <= 70; n++) begin
      tick();
      if (cfg.done) begin
        done_cycles.push_back(n);
        if (n == 13) cfg.pll_stable = 1'b1;
      end
      if (n == 50) check("retry.err_held", cfg.err, 1);
    end
    check("retry.done_count", done_cycles.size(), 3);
    if (done_cycles.size() == 3) begin
      check("retry.first_done", done_cycles[0], 6);
      check("retry.second_done", done_cycles[1], 13);
      check("retry.final_done", done_cycles[2], 13 + 1 + LAT_FULL);
    end
    check("retry.applied", cur_a(), 7'b0_001_001);
    check("retry.err_cleared", cfg.err, 0);
    $display("txn retry: done cycles=%0d applied=%0h err=%0d", done_cycles.size(), cur_a(), cfg.err);
    a_m = 7'b0_001_001;
    err_m = 1'b0;

    // Rapid toggling of req_sel must not reach the outputs.
    v1 = {a_m[6], a_m[5:3] ^ 3'd1, a_m[2:0]};
    v2 = {a_m[6], a_m[5:3] ^ 3'd2, a_m[2:0]};
    bad = 1'b0;
    for (int k = 0; k < 9; k++) begin
      drive_req((k % 2 == 0) ? v1 : v2);
      for (int j = 0; j < 2; j++) begin
        tick();
        if (cfg.done || cur_a() != a_m) bad = 1'b1;
      end
    end
    check("toggle.outputs_frozen", bad, 0);
    $display("txn toggle: outputs frozen=%0d", !bad);
    model_txn(v2, 1'b1, 0, "toggle_hold");

    // Randomised requests against the reference model.
    for (int i = 0; i < 25; i++) begin
      r    = 7'($urandom_range(0, 127));
      pll  = ($urandom_range(0, 3) != 0);
      drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 21)) : 0;
      if (r == a_m) begin
        drive_req(r);
        bad = 1'b0;
        for (int j = 0; j < 8; j++) begin
          tick();
          if (cfg.busy || cfg.done || cur_a() != a_m) bad = 1'b1;
        end
        check($sformatf("rnd%0d.same_req_idle", i), bad, 0);
        $display("txn rnd%0d: req=%0h equals applied, idle", i, r);
      end else begin
        model_txn(r, pll, drop, $sformatf("rnd%0d", i));
      end
    end

    // Reset in the middle of WAIT1 abandons the sequence.
    model_txn(7'b1_000_101, 1'b1, 0, "pre_rst_ext");
    model_txn(7'b0_000_101, 1'b0, 0, "pre_rst_refuse");
    drive_req(7'b0_110_110);
    cfg.pll_stable = 1'b1;
    for (int n = 0; n < 10; n++) tick();
    check("midrst.in_wait1_busy", cfg.busy, 1);
    rst = 1'b1;
    drive_req(7'b1_000_000);
    tick();
    rst = 1'b0;
    check("midrst.applied", cur_a(), 7'b1_000_000);
    check("midrst.status", {cfg.busy, cfg.done, cfg.err}, 3'b000);
    bad = 1'b0;
    for (int n = 0; n < 6; n++) begin
      tick();
      if (cfg.busy || cfg.done || cur_a() != 7'b1_000_000) bad = 1'b1;
    end
    check("midrst.stays_idle", bad, 0);
    $display("txn midrst: applied=%0h busy=%0d err=%0d", cur_a(), cfg.busy, cfg.err);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
